// File: rtl/dmac_ctrl_arbiter.sv
// dmac_ctrl_arbiter: round-robin sharing of the mchan control port with in-order response routing
module dmac_ctrl_arbiter #(
    parameter int NB_REQ     = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH/8,
    parameter int MAX_OUTSND = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NB_REQ-1:0]            req_i,
    input  logic [NB_REQ*ADDR_WIDTH-1:0] add_i,
    input  logic [NB_REQ-1:0]            wen_i,
    input  logic [NB_REQ*BE_WIDTH-1:0]   be_i,
    input  logic [NB_REQ*DATA_WIDTH-1:0] wdata_i,
    output logic [NB_REQ-1:0]            gnt_o,
    output logic [NB_REQ-1:0]            r_valid_o,
    output logic [DATA_WIDTH-1:0]        r_rdata_o,
    output logic                         r_opc_o,
    output logic                         mst_req_o,
    output logic [ADDR_WIDTH-1:0]        mst_add_o,
    output logic                         mst_wen_o,
    output logic [BE_WIDTH-1:0]          mst_be_o,
    output logic [DATA_WIDTH-1:0]        mst_wdata_o,
    input  logic                         mst_gnt_i,
    input  logic                         mst_r_valid_i,
    input  logic [DATA_WIDTH-1:0]        mst_r_rdata_i,
    input  logic                         mst_r_opc_i,
    output logic                         busy_o,
    output logic                         err_o
);
    localparam int IW = $clog2(NB_REQ);
    localparam int PW = $clog2(MAX_OUTSND);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d, win_q, win_d, winner, rr_win, idx, head;
    logic [IW-1:0] fifo_q [MAX_OUTSND];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   cnt_q;
    logic          err_q, locked, full, empty, hs, pop;
    assign locked    = (state_q == HOLD) && req_i[win_q];
    assign winner    = locked ? win_q : rr_win;
    assign full      = cnt_q == (PW+1)'(MAX_OUTSND);
    assign empty     = cnt_q == '0;
    assign mst_req_o = (|req_i) & ~full & ~rst_i;
    assign hs        = mst_req_o & mst_gnt_i;
    assign pop       = mst_r_valid_i & ~empty & ~rst_i;
    assign head      = fifo_q[rd_ptr_q];
    assign gnt_o     = hs ? NB_REQ'(1) << winner : '0;
    assign r_valid_o = pop ? NB_REQ'(1) << head : '0;
    assign r_rdata_o = mst_r_rdata_i;
    assign r_opc_o   = mst_r_opc_i;
    assign busy_o    = ~empty;
    assign err_o     = err_q;
    // first requester at or after the round-robin pointer, wrapping; lowest offset wins
    always_comb begin
        rr_win = rr_ptr_q;
        idx = '0;
        for (int i = NB_REQ-1; i >= 0; i--) begin
            idx = IW'((int'(rr_ptr_q) + i) % NB_REQ);
            if (req_i[idx]) rr_win = idx;
        end
    end
    // route the winner's request fields to the target port
    always_comb begin
        mst_add_o = '0;
        mst_wen_o = 1'b0;
        mst_be_o = '0;
        mst_wdata_o = '0;
        for (int p = 0; p < NB_REQ; p++) begin
            if (winner == IW'(p)) begin
                mst_add_o = add_i[p*ADDR_WIDTH +: ADDR_WIDTH];
                mst_wen_o = wen_i[p];
                mst_be_o = be_i[p*BE_WIDTH +: BE_WIDTH];
                mst_wdata_o = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end
    // lock FSM: hold the winner while the target stalls, release on handshake or dropped request
    always_comb begin
        state_d = IDLE;
        win_d = win_q;
        rr_ptr_d = rr_ptr_q;
        if (hs) begin
            rr_ptr_d = (winner == IW'(NB_REQ-1)) ? '0 : winner + IW'(1);
        end else if (mst_req_o) begin
            state_d = HOLD;
            win_d = winner;
        end
    end
    // lock state, round-robin pointer, outstanding-ID FIFO and sticky orphan-response error
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            win_q <= '0;
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q <= win_d;
            rr_ptr_q <= rr_ptr_d;
            if (hs) begin
                fifo_q[wr_ptr_q] <= winner;
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q <= cnt_q + (PW+1)'(hs) - (PW+1)'(pop);
            if (mst_r_valid_i && empty) err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dmac_ctrl_arbiter.sv
// tb_dmac_ctrl_arbiter: scoreboard bench with a queue-based reference model of the arbiter
module tb_dmac_ctrl_arbiter;
    localparam int N = 4;
    localparam int MAXO = 4;
    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [N-1:0]  req_i = '0;
    logic [N*32-1:0] add_i = '0;
    logic [N-1:0]  wen_i = '0;
    logic [N*4-1:0] be_i = '0;
    logic [N*32-1:0] wdata_i = '0;
    logic [N-1:0]  gnt_o, r_valid_o;
    logic [31:0]   r_rdata_o;
    logic          r_opc_o, mst_req_o, mst_wen_o;
    logic [31:0]   mst_add_o, mst_wdata_o;
    logic [3:0]    mst_be_o;
    logic          mst_gnt_i = 1'b0;
    logic          mst_r_valid_i = 1'b0;
    logic [31:0]   mst_r_rdata_i = '0;
    logic          mst_r_opc_i = 1'b0;
    logic          busy_o, err_o;

    dmac_ctrl_arbiter #(.NB_REQ(N), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4), .MAX_OUTSND(MAXO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .add_i(add_i), .wen_i(wen_i), .be_i(be_i),
        .wdata_i(wdata_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o), .r_opc_o(r_opc_o),
        .mst_req_o(mst_req_o), .mst_add_o(mst_add_o), .mst_wen_o(mst_wen_o), .mst_be_o(mst_be_o),
        .mst_wdata_o(mst_wdata_o), .mst_gnt_i(mst_gnt_i), .mst_r_valid_i(mst_r_valid_i),
        .mst_r_rdata_i(mst_r_rdata_i), .mst_r_opc_i(mst_r_opc_i), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {int cyc; int port; logic [31:0] data; logic opc;} ev_t;
    typedef struct {int cyc; logic mreq; logic busy; logic err; logic [31:0] add; logic wen; logic [3:0] be; logic [31:0] wdata;} st_t;
    ev_t gq[$];
    ev_t rq[$];
    st_t sq[$];
    int  oq[$];
    int  m_rr, m_lp, cyc, n_vec, n_err;
    bit  m_lock, m_err;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // one clock of stimulus; the model predicts this cycle's outputs and then advances its state
    task automatic step(input logic [3:0] rqv, input logic g, input logic rv, input logic [31:0] rd, input logic ro, input logic rs);
        st_t s;
        ev_t e;
        int w;
        bit mreq;
        @(posedge clk_i);
        #1;
        cyc++;
        req_i = rqv;
        mst_gnt_i = g;
        mst_r_valid_i = rv;
        mst_r_rdata_i = rd;
        mst_r_opc_i = ro;
        rst_i = rs;
        for (int p = 0; p < N; p++) begin
            add_i[p*32 +: 32] = $urandom;
            wdata_i[p*32 +: 32] = $urandom;
            be_i[p*4 +: 4] = 4'($urandom);
            wen_i[p] = 1'($urandom);
        end
        mreq = (rqv != 0) && (oq.size() < MAXO) && !rs;
        w = -1;
        if (mreq) begin
            if (m_lock && rqv[m_lp]) w = m_lp;
            else for (int i = 0; i < N; i++) if (w < 0 && rqv[(m_rr + i) % N]) w = (m_rr + i) % N;
        end
        s.cyc = cyc;
        s.mreq = mreq;
        s.busy = oq.size() != 0;
        s.err = m_err;
        s.add = 0; s.wen = 0; s.be = 0; s.wdata = 0;
        if (w >= 0) begin
            s.add = add_i[w*32 +: 32];
            s.wen = wen_i[w];
            s.be = be_i[w*4 +: 4];
            s.wdata = wdata_i[w*32 +: 32];
        end
        sq.push_back(s);
        if (rs) begin
            oq.delete();
            m_rr = 0; m_lock = 0; m_err = 0;
            return;
        end
        if (rv) begin
            if (oq.size() > 0) begin
                e.cyc = cyc; e.port = oq.pop_front(); e.data = rd; e.opc = ro;
                rq.push_back(e);
            end else m_err = 1;
        end
        if (mreq && g) begin
            e.cyc = cyc; e.port = w; e.data = 0; e.opc = 0;
            gq.push_back(e);
            oq.push_back(w);
            m_rr = (w + 1) % N;
            m_lock = 0;
        end else if (mreq) begin
            m_lock = 1;
            m_lp = w;
        end else m_lock = 0;
    endtask

    // monitor: pops the expectations for the current cycle and compares against the DUT outputs
    always @(negedge clk_i) begin
        st_t s;
        ev_t e;
        logic [3:0] eg, er;
        logic [31:0] ed;
        logic eo;
        if (sq.size() > 0 && sq[0].cyc == cyc) begin
            s = sq.pop_front();
            chk("mst_req", 64'(mst_req_o), 64'(s.mreq));
            chk("busy", 64'(busy_o), 64'(s.busy));
            chk("err", 64'(err_o), 64'(s.err));
            if (s.mreq) begin
                chk("mst_add", 64'(mst_add_o), 64'(s.add));
                chk("mst_wen", 64'(mst_wen_o), 64'(s.wen));
                chk("mst_be", 64'(mst_be_o), 64'(s.be));
                chk("mst_wdata", 64'(mst_wdata_o), 64'(s.wdata));
            end
        end
        eg = '0;
        if (gq.size() > 0 && gq[0].cyc == cyc) begin
            e = gq.pop_front();
            eg = 4'b1 << e.port;
        end
        if (gnt_o != 0 || eg != 0) chk("gnt", 64'(gnt_o), 64'(eg));
        er = '0; ed = '0; eo = 1'b0;
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
            e = rq.pop_front();
            er = 4'b1 << e.port; ed = e.data; eo = e.opc;
        end
        if (r_valid_o != 0 || er != 0) begin
            chk("r_valid", 64'(r_valid_o), 64'(er));
            if (er != 0) begin
                chk("r_rdata", 64'(r_rdata_o), 64'(ed));
                chk("r_opc", 64'(r_opc_o), 64'(eo));
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk_i);
        step(4'b0000, 0, 0, 0, 0, 1);
        step(4'b0001, 1, 0, 0, 0, 0);
        step(4'b0001, 1, 0, 0, 0, 0);
        step(4'b0000, 0, 1, 32'h0, 0, 0);
        step(4'b0000, 0, 1, 32'hDEADBEEF, 0, 0);
        step(4'b0000, 0, 0, 0, 0, 1);
        step(4'b1111, 1, 0, 0, 0, 0);
        repeat (5) step(4'b1111, 1, 1, $urandom, 0, 0);
        step(4'b0000, 0, 0, 0, 0, 1);
        step(4'b0010, 0, 0, 0, 0, 0);
        step(4'b0010, 0, 0, 0, 0, 0);
        step(4'b0011, 0, 0, 0, 0, 0);
        step(4'b0011, 1, 0, 0, 0, 0);
        step(4'b0011, 1, 0, 0, 0, 0);
        step(4'b0000, 0, 0, 0, 0, 1);
        repeat (4) step(4'b0100, 1, 0, 0, 0, 0);
        step(4'b0100, 1, 0, 0, 0, 0);
        step(4'b0100, 1, 1, 32'h5, 1, 0);
        step(4'b0100, 1, 0, 0, 0, 0);
        step(4'b0000, 0, 0, 0, 0, 1);
        step(4'b0100, 1, 0, 0, 0, 0);
        step(4'b0001, 1, 0, 0, 0, 0);
        step(4'b0000, 0, 1, 32'h11, 0, 0);
        step(4'b0000, 0, 1, 32'h22, 1, 0);
        step(4'b0000, 0, 0, 0, 0, 0);
        step(4'b0000, 0, 0, 0, 0, 1);
        step(4'b0000, 0, 1, 32'h33, 0, 0);
        step(4'b0000, 0, 0, 0, 0, 0);
        step(4'b1010, 1, 0, 0, 0, 0);
        step(4'b1010, 1, 0, 0, 0, 0);
        step(4'b0000, 0, 0, 0, 0, 1);
        step(4'b0000, 0, 0, 0, 0, 0);
        step(4'b0000, 0, 1, 32'h44, 0, 0);
        step(4'b0000, 0, 0, 0, 0, 0);
        step(4'b0000, 0, 0, 0, 0, 1);
        for (int k = 0; k < 1500; k++)
            step(4'($urandom), 1'($urandom), (oq.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 49) == 0),
                 $urandom, 1'($urandom), $urandom_range(0, 99) == 0);
        repeat (2) step(4'b0000, 0, 0, 0, 0, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        chk("leftover", 64'(gq.size() + rq.size() + sq.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
